debounce_sync: RTL and testbench

- Input conditioning stage that sits directly upstream of the team's resettable D flip-flop and registered logic.
- Takes an asynchronous, possibly bouncing 1-bit input (button/switch) and synchronises it into clk.
- Qualifies the input with a consecutive-cycle stability counter and drives a clean level plus one-cycle rise/fall strobes.
- The clean level feeds the d input of the downstream flop stage.

---
 rtl/debounce_sync.sv | 120 ++++++++++++
 tb/tb_debounce_sync.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Purpose: synchronise a raw async input and debounce it into a clean level with rise/fall strobes.
// Latency: q_clean follows a stable din on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th sampling edge.
// Backpressure: none; free-running conditioning stage. Optional macro DEBOUNCE_EDGE_CNT_EN adds edge_count.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic             q_clean,
    output logic             rise,
    output logic             fall
`ifdef DEBOUNCE_EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_count
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // Count value at which the next disagreeing sample is the qualifying one.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   q_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser chain: din enters at bit 0 and shifts toward the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            q_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            q_clean <= q_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
        end
    end

    // Next-state logic: qualify a run of samples that disagree with q_clean.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q_clean;
        case (state)
            IDLE: begin
                if (s != q_clean) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        q_nxt = s;
                    end else begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = CHECK;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            CHECK: begin
                if (s == q_clean) begin
                    // Bounced back before qualifying: drop the partial count.
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    q_nxt     = s;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        rise_nxt = q_nxt & ~q_clean;
        fall_nxt = ~q_nxt & q_clean;
    end

`ifdef DEBOUNCE_EDGE_CNT_EN
    // Free-running count of qualified rising edges; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_count <= '0;
        end else if (rise) begin
            edge_count <= edge_count + CNT_W'(1);
        end
    end
`else
    // Edge counter not built in this configuration.
`endif

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

    logic       clk;
    logic       reset;
    logic       din;
    logic       q_clean;
    logic       rise;
    logic       fall;
`ifdef DEBOUNCE_EDGE_CNT_EN
    logic [7:0] edge_count;
`endif

    int checks;
    int errors;

    debounce_sync #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .q_clean   (q_clean),
        .rise      (rise),
        .fall      (fall)
`ifdef DEBOUNCE_EDGE_CNT_EN
        ,
        .edge_count(edge_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive din to val (from a settled opposite level) and check the 8 following edges.
    // q_clean must flip on edge 6 with exactly one matching strobe.
    task automatic run_edge(input logic val, input string name);
        logic exp_q;
        logic exp_r;
        logic exp_f;
        din = val;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_q = (n >= 6) ? val : ~val;
            exp_r = (val == 1'b1) && (n == 6);
            exp_f = (val == 1'b0) && (n == 6);
            checks++;
            if (q_clean !== exp_q || rise !== exp_r || fall !== exp_f) begin
                errors++;
                $display("FAIL %s edge %0d: q_clean=%b rise=%b fall=%b, expected q_clean=%b rise=%b fall=%b",
                         name, n, q_clean, rise, fall, exp_q, exp_r, exp_f);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din   = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if (q_clean !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                errors++;
                $display("FAIL reset edge %0d: q_clean=%b rise=%b fall=%b, expected all 0",
                         n, q_clean, rise, fall);
            end
        end
`ifdef DEBOUNCE_EDGE_CNT_EN
        checks++;
        if (edge_count !== 8'd0) begin
            errors++;
            $display("FAIL reset edge_count: got %0d expected 0", edge_count);
        end
`endif
        reset = 1'b0;
        run_edge(1'b1, "rise_after_reset");
    endtask

    task automatic test_fall();
        run_edge(1'b0, "fall");
    endtask

    task automatic test_rise();
        run_edge(1'b1, "rise");
    endtask

    task automatic test_bounce();
        din = 1'b1;
        repeat (3) tick();
        din = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (q_clean !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
                errors++;
                $display("FAIL bounce cycle %0d: q_clean=%b rise=%b fall=%b, expected all 0",
                         n, q_clean, rise, fall);
            end
        end
        checks++;
        if (dut.cnt !== 8'd0) begin
            errors++;
            $display("FAIL bounce cnt: got %0d expected 0", dut.cnt);
        end
    endtask

    task automatic test_reset_mid_check();
        din = 1'b1;
        repeat (4) tick();
        checks++;
        if (dut.cnt !== 8'd2 || q_clean !== 1'b0) begin
            errors++;
            $display("FAIL midcheck pre-reset: cnt=%0d q_clean=%b, expected cnt=2 q_clean=0",
                     dut.cnt, q_clean);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (dut.cnt !== 8'd0 || dut.sync !== 2'b00 || q_clean !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) begin
            errors++;
            $display("FAIL midcheck reset: cnt=%0d sync=%b q_clean=%b rise=%b fall=%b, expected all 0",
                     dut.cnt, dut.sync, q_clean, rise, fall);
        end
        reset = 1'b0;
        run_edge(1'b1, "midcheck_release");
    endtask

    task automatic test_toggle();
        for (int n = 1; n <= 40; n++) begin
            din = ~din;
            tick();
            checks++;
            if (q_clean !== 1'b1 || rise !== 1'b0 || fall !== 1'b0) begin
                errors++;
                $display("FAIL toggle cycle %0d: q_clean=%b rise=%b fall=%b, expected 1 0 0",
                         n, q_clean, rise, fall);
            end
        end
        din = 1'b1;
        repeat (8) tick();
        checks++;
        if (q_clean !== 1'b1) begin
            errors++;
            $display("FAIL toggle settle: q_clean=%b expected 1", q_clean);
        end
    endtask

`ifdef DEBOUNCE_EDGE_CNT_EN
    task automatic test_edge_count();
        din   = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (edge_count !== 8'd0) begin
            errors++;
            $display("FAIL edge_count after reset: got %0d expected 0", edge_count);
        end
        for (int i = 1; i <= 256; i++) begin
            din = 1'b1;
            repeat (8) tick();
            if (i == 1 || i == 255 || i == 256) begin
                checks++;
                if (edge_count !== 8'(i)) begin
                    errors++;
                    $display("FAIL edge_count after rise %0d: got %0d expected %0d",
                             i, edge_count, 8'(i));
                end
            end
            din = 1'b0;
            repeat (8) tick();
        end
        checks++;
        if (edge_count !== 8'd0) begin
            errors++;
            $display("FAIL edge_count after falls: got %0d expected 0", edge_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        din    = 1'b0;
        test_reset();
        test_fall();
        test_bounce();
        test_reset_mid_check();
        test_toggle();
        test_fall();
        test_rise();
`ifdef DEBOUNCE_EDGE_CNT_EN
        test_edge_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
